// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: game-phase FSM, tick dividers and single-strobe action arbiter.
// Define GAME_TICK_SCHED_UFO_EN to build the UFO-spawn channel; otherwise ufo_stb is tied low.
module game_tick_scheduler #(
    parameter int MOVE_PERIOD     = 8,
    parameter int MIN_MOVE_PERIOD = 2,
    parameter int SHOT_PERIOD     = 20,
    parameter int UFO_PERIOD      = 50,
    parameter int LEVEL_GAP       = 3,
    parameter int TURBO_THRESH    = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       tick,
    input  logic       start,
    input  logic       pause_req,
    input  logic       level_done,
    input  logic       game_over,
    input  logic [5:0] aliens_left,
    output logic       turbo,
    output logic       move_stb,
    output logic       shot_stb,
    output logic       ufo_stb,
    output logic [1:0] state,
    output logic [3:0] level
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_LEVEL_UP = 2'd3
    } state_e;

`ifdef GAME_TICK_SCHED_UFO_EN
    localparam int NUM_CH = 3;
`else
    localparam int NUM_CH = 2;
`endif

    localparam logic [7:0] MOVE_P  = 8'(MOVE_PERIOD);
    localparam logic [7:0] MIN_P   = 8'(MIN_MOVE_PERIOD);
    localparam logic [7:0] SHOT_P  = 8'(SHOT_PERIOD);
    localparam logic [7:0] UFO_P   = 8'(UFO_PERIOD);
    localparam logic [7:0] GAP_P   = 8'(LEVEL_GAP);
    localparam logic [7:0] TURBO_T = 8'(TURBO_THRESH);

    state_e            state_q, state_d;
    logic [3:0]        level_q, level_d;
    logic [7:0]        gap_q, gap_d;
    logic [7:0]        cnt_q [NUM_CH];
    logic [7:0]        cnt_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] stb_q, stb_d;
    logic              turbo_q, turbo_d;

    logic [7:0]        lvl_ext;
    logic [7:0]        move_period;
    logic [7:0]        period [NUM_CH];
    logic              count_en, clear_cnt, clear_pend;
    logic [NUM_CH-1:0] expired, pend_all, grant;

    // Level-adjusted move period, floored at MIN_P without wrapping below zero.
    always_comb begin
        lvl_ext     = {4'd0, level_q};
        move_period = MIN_P;
        if ({1'b0, MOVE_P} > ({1'b0, MIN_P} + {1'b0, lvl_ext})) begin
            move_period = MOVE_P - lvl_ext;
        end
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        gap_d      = gap_q;
        count_en   = 1'b0;
        clear_cnt  = 1'b0;
        clear_pend = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    level_d    = '0;
                    clear_cnt  = 1'b1;
                    clear_pend = 1'b1;
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    state_d    = ST_IDLE;
                    clear_pend = 1'b1;
                end else if (level_done) begin
                    state_d = ST_LEVEL_UP;
                    level_d = (level_q == 4'hF) ? level_q : level_q + 4'd1;
                    gap_d   = '0;
                end else if (pause_req) begin
                    state_d = ST_PAUSED;
                end else begin
                    count_en = tick;
                end
            end
            ST_PAUSED: begin
                if (game_over) begin
                    state_d    = ST_IDLE;
                    clear_pend = 1'b1;
                end else if (pause_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (game_over) begin
                    state_d    = ST_IDLE;
                    clear_pend = 1'b1;
                end else if (tick) begin
                    if (({1'b0, gap_q} + 9'd1) >= {1'b0, GAP_P}) begin
                        state_d   = ST_RUN;
                        clear_cnt = 1'b1;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
            end
        endcase
    end

    // Channel dividers, pending merge and fixed-priority grant (lowest index wins).
    always_comb begin
        expired = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            period[i] = (i == 0) ? move_period : ((i == 1) ? SHOT_P : UFO_P);
            cnt_d[i]  = cnt_q[i];
            if (clear_cnt) begin
                cnt_d[i] = '0;
            end else if (count_en) begin
                if (({1'b0, cnt_q[i]} + 9'd1) >= {1'b0, period[i]}) begin
                    cnt_d[i]   = '0;
                    expired[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end

        pend_all = clear_pend ? '0 : (pend_q | expired);
        grant    = '0;
        // Newly expired channels are eligible this cycle, giving tick+1 strobe latency.
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (pend_all[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                end
            end
        end
        pend_d  = pend_all & ~grant;
        stb_d   = grant;
        turbo_d = (state_q == ST_RUN) && ({2'b00, aliens_left} <= TURBO_T);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            gap_q   <= '0;
            pend_q  <= '0;
            stb_q   <= '0;
            turbo_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            stb_q   <= stb_d;
            turbo_q <= turbo_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign turbo    = turbo_q;
    assign move_stb = stb_q[0];
    assign shot_stb = stb_q[1];
`ifdef GAME_TICK_SCHED_UFO_EN
    assign ufo_stb  = stb_q[2];
`else
    assign ufo_stb  = 1'b0;
`endif
    assign state    = state_q;
    assign level    = level_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler: vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the game scheduler.
module tb_game_tick_scheduler;

    localparam int MOVE_PERIOD     = 8;
    localparam int MIN_MOVE_PERIOD = 2;
    localparam int SHOT_PERIOD     = 20;
    localparam int UFO_PERIOD      = 50;
    localparam int LEVEL_GAP       = 3;
    localparam int TURBO_THRESH    = 8;
`ifdef GAME_TICK_SCHED_UFO_EN
    localparam bit UFO_EN = 1'b1;
`else
    localparam bit UFO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN;
    logic       tick, start, pause_req, level_done, game_over;
    logic [5:0] aliens_left;
    logic       turbo, move_stb, shot_stb, ufo_stb;
    logic [1:0] state;
    logic [3:0] level;

    int n_checks = 0;
    int n_pass   = 0;

    game_tick_scheduler #(
        .MOVE_PERIOD(MOVE_PERIOD), .MIN_MOVE_PERIOD(MIN_MOVE_PERIOD),
        .SHOT_PERIOD(SHOT_PERIOD), .UFO_PERIOD(UFO_PERIOD),
        .LEVEL_GAP(LEVEL_GAP), .TURBO_THRESH(TURBO_THRESH)
    ) dut (
        .clk(clk), .resetN(resetN), .tick(tick), .start(start),
        .pause_req(pause_req), .level_done(level_done), .game_over(game_over),
        .aliens_left(aliens_left), .turbo(turbo), .move_stb(move_stb),
        .shot_stb(shot_stb), .ufo_stb(ufo_stb), .state(state), .level(level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Behavioural model: phase 0 idle, 1 run, 2 paused, 3 level-up.
    int m_phase, m_level, m_gap;
    int m_cnt [3];
    bit m_pend [3];
    bit m_stb [3];
    bit m_turbo;

    task automatic model_reset();
        m_phase = 0; m_level = 0; m_gap = 0; m_turbo = 0;
        for (int c = 0; c < 3; c++) begin
            m_cnt[c] = 0; m_pend[c] = 0; m_stb[c] = 0;
        end
    endtask

    task automatic model_step(input bit t, input bit st, input bit pr, input bit ld,
                              input bit go, input int al);
        int nxt, mp, pick, per, n_ch;
        bit clr_cnt, clr_pend, counting;
        nxt = m_phase; clr_cnt = 0; clr_pend = 0; counting = 0;
        n_ch = UFO_EN ? 3 : 2;
        mp = MOVE_PERIOD - m_level;
        if (mp < MIN_MOVE_PERIOD) mp = MIN_MOVE_PERIOD;
        m_turbo = (m_phase == 1) && (al <= TURBO_THRESH);

        if (m_phase == 0) begin
            if (st) begin nxt = 1; m_level = 0; clr_cnt = 1; clr_pend = 1; end
        end else if (go) begin
            nxt = 0; clr_pend = 1;
        end else if (m_phase == 1) begin
            if (ld) begin
                nxt = 3; m_gap = 0;
                if (m_level < 15) m_level++;
            end else if (pr) nxt = 2;
            else counting = t;
        end else if (m_phase == 2) begin
            if (pr) nxt = 1;
        end else if (t) begin
            m_gap++;
            if (m_gap >= LEVEL_GAP) begin nxt = 1; clr_cnt = 1; end
        end

        if (counting) begin
            for (int c = 0; c < n_ch; c++) begin
                per = (c == 0) ? mp : ((c == 1) ? SHOT_PERIOD : UFO_PERIOD);
                m_cnt[c]++;
                if (m_cnt[c] >= per) begin m_cnt[c] = 0; m_pend[c] = 1; end
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (clr_cnt)  m_cnt[c] = 0;
            if (clr_pend) m_pend[c] = 0;
            m_stb[c] = 0;
        end
        pick = -1;
        if (m_phase == 1 && nxt == 1) begin
            for (int c = 0; c < n_ch; c++) if (pick < 0 && m_pend[c]) pick = c;
        end
        if (pick >= 0) begin m_stb[pick] = 1; m_pend[pick] = 0; end
        m_phase = nxt;
    endtask

    function automatic logic [9:0] dut_vec();
        return {state, level, move_stb, shot_stb, ufo_stb, turbo};
    endfunction

    function automatic logic [9:0] model_vec();
        return {2'(m_phase), 4'(m_level), m_stb[0], m_stb[1], m_stb[2], m_turbo};
    endfunction

    // Drives one cycle of inputs from a falling edge and compares against the model.
    task automatic step(input bit t, input bit st, input bit pr, input bit ld,
                        input bit go, input int al);
        tick = t; start = st; pause_req = pr; level_done = ld; game_over = go;
        aliens_left = 6'(al);
        model_step(t, st, pr, ld, go, al);
        @(posedge clk);
        @(negedge clk);
        check("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick = 0; start = 0; pause_req = 0; level_done = 0; game_over = 0;
        aliens_left = 6'd30;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", 32'(dut_vec()), 32'd0);
        resetN = 1'b1;
    endtask

    typedef struct {
        bit         t, st, pr, ld, go;
        logic [5:0] al;
        logic [1:0] e_state;
        logic [3:0] e_level;
        bit         e_turbo;
    } vec_t;

    function automatic vec_t mk(input bit t, input bit st, input bit pr, input bit ld,
                                input bit go, input int al, input int es, input int el,
                                input bit et);
        vec_t v;
        v.t = t; v.st = st; v.pr = pr; v.ld = ld; v.go = go;
        v.al = 6'(al); v.e_state = 2'(es); v.e_level = 4'(el); v.e_turbo = et;
        return v;
    endfunction

    vec_t vt [14];

    initial begin
        int mv, sh, uf, both, strobes, found, n;

        //         t  st pr ld go al   state lvl turbo
        vt[0]  = mk(0, 1, 0, 0, 0, 30, 1, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 0, 5,  1, 0, 1);
        vt[2]  = mk(0, 0, 1, 0, 0, 5,  2, 0, 1);
        vt[3]  = mk(1, 0, 0, 0, 0, 5,  2, 0, 0);
        vt[4]  = mk(0, 0, 1, 0, 0, 30, 1, 0, 0);
        vt[5]  = mk(0, 0, 0, 1, 0, 30, 3, 1, 0);
        vt[6]  = mk(1, 0, 0, 0, 0, 30, 3, 1, 0);
        vt[7]  = mk(1, 0, 0, 0, 0, 30, 3, 1, 0);
        vt[8]  = mk(1, 0, 0, 0, 0, 30, 1, 1, 0);
        vt[9]  = mk(0, 0, 0, 0, 1, 30, 0, 1, 0);
        vt[10] = mk(0, 0, 1, 0, 0, 30, 0, 1, 0);
        vt[11] = mk(0, 1, 0, 0, 1, 30, 1, 0, 0);
        vt[12] = mk(0, 0, 1, 1, 0, 30, 3, 1, 0);
        vt[13] = mk(1, 0, 0, 0, 1, 30, 0, 1, 0);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(vt[i].t, vt[i].st, vt[i].pr, vt[i].ld, vt[i].go, int'(vt[i].al));
            check($sformatf("vec%0d", i), 32'(dut_vec()),
                  32'({vt[i].e_state, vt[i].e_level, 3'b000, vt[i].e_turbo}));
        end

        // Basic division and the tick-40 move/shot collision.
        do_reset();
        step(0, 1, 0, 0, 0, 30);
        mv = 0; sh = 0; uf = 0; both = 0;
        for (int k = 1; k <= 40; k++) begin
            for (int c = 0; c < 4; c++) begin
                step(c == 0, 0, 0, 0, 0, 30);
                mv += int'(move_stb); sh += int'(shot_stb); uf += int'(ufo_stb);
                if (move_stb && shot_stb) both++;
                if (k == 40 && c == 0) check("collision_tick_plus1", {move_stb, shot_stb}, 2'b10);
                if (k == 40 && c == 1) check("collision_tick_plus2", {move_stb, shot_stb}, 2'b01);
            end
        end
        check("basic_move_count", mv, 5);
        check("basic_shot_count", sh, 2);
        check("basic_ufo_count", uf, 0);
        check("basic_overlap", both, 0);
        check("basic_turbo", turbo, 0);
        check("basic_state", state, 1);

        // Pause holds counters and pendings; resume picks up the remaining move count.
        do_reset();
        step(0, 1, 0, 0, 0, 30);
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0, 30);
        step(0, 0, 1, 0, 0, 30);
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            step(1, 0, 0, 0, 0, 30);
            strobes += int'(move_stb) + int'(shot_stb) + int'(ufo_stb);
        end
        check("pause_no_strobes", strobes, 0);
        check("pause_state", state, 2);
        step(0, 0, 1, 0, 0, 30);
        found = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1, 0, 0, 0, 0, 30);
            if (move_stb && found == 0) found = k;
        end
        check("resume_move_ticks", found, 3);

        // Three level-ups, each gap lasting LEVEL_GAP ticks; period drops to 5.
        do_reset();
        step(0, 1, 0, 0, 0, 30);
        for (int lu = 0; lu < 3; lu++) begin
            step(0, 0, 0, 1, 0, 30);
            n = 0;
            while (state != 2'd1 && n < 8) begin
                step(1, 0, 0, 0, 0, 30);
                n++;
            end
            check($sformatf("levelup%0d_ticks", lu), n, 3);
        end
        check("level_after_3", level, 3);
        found = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1, 0, 0, 0, 0, 30);
            if (move_stb && found == 0) found = k;
        end
        check("level3_move_period", found, 5);

        // Turbo threshold and game_over.
        do_reset();
        step(0, 1, 0, 0, 0, 9);
        step(0, 0, 0, 0, 0, 9);
        check("turbo_at_9", turbo, 0);
        step(0, 0, 0, 0, 0, 8);
        check("turbo_rise_at_8", turbo, 1);
        step(0, 0, 0, 0, 1, 8);
        step(0, 0, 0, 0, 0, 8);
        check("turbo_after_over", turbo, 0);
        check("state_after_over", state, 0);

        // Asynchronous reset while a move strobe is in flight.
        do_reset();
        step(0, 1, 0, 0, 0, 30);
        for (int k = 0; k < 8; k++) step(1, 0, 0, 0, 0, 30);
        check("move_before_reset", move_stb, 1);
        resetN = 1'b0;
        #1;
        check("reset_async_outputs", 32'(dut_vec()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset_held_outputs", 32'(dut_vec()), 32'd0);
        model_reset();
        resetN = 1'b1;

        // UFO channel: one spawn after 50 ticks only when the channel is built.
        step(0, 1, 0, 0, 0, 30);
        uf = 0;
        for (int k = 0; k < 50; k++) begin
            for (int c = 0; c < 4; c++) begin
                step(c == 0, 0, 0, 0, 0, 30);
                uf += int'(ufo_stb);
            end
        end
        check("ufo_count_50_ticks", uf, UFO_EN ? 1 : 0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 2500; k++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 149) == 0, int'($urandom_range(0, 16)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Sequences Space Invaders game actions off the slow timebase. Consumes the one-cycle tick pulse from the one-second counter and drives that counter's turbo input. Runs the game-phase state machine and divides ticks into alien-move, alien-shot and UFO-spawn requests. Arbitrates those requests so the shared sprite-update datapath receives at most one action strobe per clock.

## Interface
Parameters:
- MOVE_PERIOD, 8, ticks between alien moves at level 0
- MIN_MOVE_PERIOD, 2, floor for the level-adjusted move period
- SHOT_PERIOD, 20, ticks between alien shots
- UFO_PERIOD, 50, ticks between UFO spawns
- LEVEL_GAP, 3, ticks spent in LEVEL_UP before resuming
- TURBO_THRESH, 8, turbo asserted when aliens_left ≤ this value

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle pulse from the timebase
- start  in  1  pulse; begins a game
- pause_req  in  1  pulse; toggles RUN and PAUSED
- level_done  in  1  pulse; all aliens cleared
- game_over  in  1  pulse; player lost
- aliens_left  in  6  live alien count
- turbo  out  1  to the timebase turbo input
- move_stb  out  1  one-cycle alien-move action
- shot_stb  out  1  one-cycle alien-shot action
- ufo_stb  out  1  one-cycle UFO-spawn action
- state  out  2  0 IDLE, 1 RUN, 2 PAUSED, 3 LEVEL_UP
- level  out  4  current level

## Operation
- **Reset values:** state IDLE, level 0, all strobes 0, turbo 0, channel counters 0, pending flags 0, gap counter 0.
- **Event priority when several arrive in one cycle:** game_over > level_done > pause_req > start.
- **FSM transitions:**
  - IDLE –start→ RUN. This transition sets level 0 and clears counters and pendings.
  - RUN –pause_req→ PAUSED.
  - PAUSED –pause_req→ RUN.
  - RUN –level_done→ LEVEL_UP. This transition increments level, saturating at 15, and clears the gap counter.
  - LEVEL_UP → RUN after LEVEL_GAP ticks. Counters are cleared on entry to RUN.
  - Any non-IDLE state –game_over→ IDLE. Pendings are cleared on this transition.
  - Inputs not listed for the current state are ignored.
- **Channel counters** run only in RUN. Each counter increments on tick. When count+1 ≥ period, the counter clears and the channel's pending flag is set.
- **Move period:** max(MIN_MOVE_PERIOD, MOVE_PERIOD − level). Compute it with 8-bit unsigned arithmetic and no underflow.
- **Arbitration:**
  - Each cycle in RUN, the highest-priority pending flag is strobed and cleared. Priority is move > shot > ufo.
  - Pendings persist through PAUSED and LEVEL_UP. No strobe fires outside RUN.
  - A pending flag set while it is already pending merges, so at most one action per channel is outstanding.
- **turbo** = 1 when state is RUN and aliens_left ≤ TURBO_THRESH; otherwise 0. It is registered.

## Timing
- Strobes are registered. The earliest strobe comes 1 cycle after the tick that set the pending flag.
- When three channels expire on the same tick:
  - move_stb fires at tick+1.
  - shot_stb fires at tick+2.
  - ufo_stb fires at tick+3.
- Strobes are mutually exclusive. Each lasts exactly one cycle.
- state and level update 1 cycle after the causing pulse.
- turbo follows aliens_left and state with 1-cycle latency.
- A tick coincident with pause_req is not counted.
- A tick coincident with a transition into RUN is not counted.
- A tick coincident with level_done is not counted.
- Asserting resetN low mid-operation immediately forces all reset values, including deasserting any in-flight strobe.

## Configuration
- Macro: GAME_TICK_SCHED_UFO_EN.
- **Defined:** UFO counter, pending flag and arbitration slot are present as described.
- **Undefined:**
  - The UFO logic is absent and ufo_stb is tied to 0.
  - Arbitration covers only move and shot.
  - UFO_PERIOD is unused.

## Test plan
- **Basic division:** Reset, start, 40 ticks with default parameters and aliens_left = 30. Required: 5 move_stb, 2 shot_stb, 0 ufo_stb; turbo = 0; state = 1.
- **Collision:** Run to tick 40, where move and shot both expire. Required: move_stb at tick+1, shot_stb at tick+2, never both high in the same cycle.
- **Pause:** pause_req at tick 5, 20 ticks while paused, then pause_req. Required: no strobes while paused; the next move_stb comes 3 ticks after resume.
- **Level up:** level_done three times. Required: level = 3; LEVEL_UP lasts 3 ticks each time; move period becomes 5.
- **Turbo:** Drop aliens_left from 9 to 8 in RUN. Required: turbo rises 1 cycle later; turbo is 0 after game_over.
- **Reset and config:** Assert resetN low in the same cycle as a move_stb. Required: all outputs are 0 next cycle. With the macro undefined, 50 ticks produce ufo_stb = 0 throughout.
